// File: rtl/cv32e41p_clk_en_ctrl.sv
// Clock-enable producer for the core clock gate: gates after a quiescent WFI
// hysteresis window and re-enables on wake with a fixed settle window.
module cv32e41p_clk_en_ctrl #(
  parameter int HYST_CYCLES = 2,
  parameter int WAKE_CYCLES = 1
) (
  input  logic clk_ungated_i,
  input  logic rst_n,
  input  logic fetch_enable_i,
  input  logic wfi_i,
  input  logic busy_i,
  input  logic wake_req_i,
  output logic clock_en_o,
  output logic core_sleep_o,
  output logic wake_o
);

  localparam int HW = $clog2(HYST_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [HW-1:0] HYST_MAX = HW'(HYST_CYCLES);
  localparam logic [WW-1:0] WAKE_MAX = WW'(WAKE_CYCLES);

  if (HYST_CYCLES < 1) begin : g_bad_hyst
    $error("HYST_CYCLES must be >= 1");
  end
  if (WAKE_CYCLES < 1) begin : g_bad_wake
    $error("WAKE_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_SLEEP = 3'd3,
    S_WAKE  = 3'd4
  } state_t;

  state_t        r_state;
  logic [HW-1:0] r_hyst_cnt;
  logic [WW-1:0] r_wake_cnt;
  logic          r_clock_en;
  logic          r_core_sleep;
  logic          r_wake;

  logic [HW-1:0] w_hyst_inc;
  logic [WW-1:0] w_wake_inc;

  // Counters never exceed their limit, so the increment cannot overflow.
  assign w_hyst_inc = (r_hyst_cnt == HYST_MAX) ? r_hyst_cnt : r_hyst_cnt + 1'b1;
  assign w_wake_inc = (r_wake_cnt == WAKE_MAX) ? r_wake_cnt : r_wake_cnt + 1'b1;

  // NOTE: outputs are assigned alongside the state they belong to, with
  // non-blocking assignments, so every output is a flop with no input path.
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_OFF;
      r_hyst_cnt   <= '0;
      r_wake_cnt   <= '0;
      r_clock_en   <= 1'b0;
      r_core_sleep <= 1'b0;
      r_wake       <= 1'b0;
    end else begin
      r_wake <= 1'b0;
      case (r_state)
        S_OFF: begin
          if (fetch_enable_i) begin
            r_state    <= S_RUN;
            r_clock_en <= 1'b1;
          end
        end
        S_RUN: begin
          if (wfi_i && !wake_req_i) begin
            r_state    <= S_DRAIN;
            r_hyst_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (wake_req_i || !wfi_i) begin
            r_state    <= S_RUN;
            r_hyst_cnt <= '0;
          end else if (busy_i) begin
            r_hyst_cnt <= '0;
          end else begin
            r_hyst_cnt <= w_hyst_inc;
            if (w_hyst_inc == HYST_MAX) begin
              r_state      <= S_SLEEP;
              r_clock_en   <= 1'b0;
              r_core_sleep <= 1'b1;
            end
          end
        end
        S_SLEEP: begin
          if (wake_req_i) begin
            r_state      <= S_WAKE;
            r_wake_cnt   <= '0;
            r_clock_en   <= 1'b1;
            r_core_sleep <= 1'b0;
          end
        end
        S_WAKE: begin
          r_wake_cnt <= w_wake_inc;
          if (w_wake_inc == WAKE_MAX) begin
            r_state <= S_RUN;
            r_wake  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_OFF;
          r_hyst_cnt   <= '0;
          r_wake_cnt   <= '0;
          r_clock_en   <= 1'b0;
          r_core_sleep <= 1'b0;
        end
      endcase
    end
  end

  assign clock_en_o   = r_clock_en;
  assign core_sleep_o = r_core_sleep;
  assign wake_o       = r_wake;

endmodule
